// File: rtl/device_event_encoder.sv
// Serialises per-device on/off level changes into one connect/disconnect event per cycle.
// Pending events are granted round-robin; opposite toggles that have not been emitted yet cancel.
module device_event_encoder #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic             busy
);

  logic [N_DEV-1:0] status_q;
  logic [N_DEV-1:0] pend_q;
  logic [N_DEV-1:0] dir_q;
  logic [ID_W-1:0]  ptr_q;
  logic             change_q;
  logic             onOff_q;
  logic [ID_W-1:0]  devId_q;
  logic             busy_q;

  logic [N_DEV-1:0] toggle;
  logic [N_DEV-1:0] grantVec;
  logic [N_DEV-1:0] pend_d;
  logic [N_DEV-1:0] dir_d;
  logic [ID_W-1:0]  ptr_d;
  logic             grantValid;
  logic [ID_W-1:0]  grantIdx;
  logic [ID_W:0]    grantRaw;

  // Scanning downward lets the lowest offset from start win, i.e. the first pending device at or after start.
  function automatic logic [ID_W:0] findGrant(input logic [N_DEV-1:0] pend,
                                             input logic [ID_W-1:0]  start);
    logic [ID_W:0]   result;
    logic [ID_W-1:0] idx;
    result = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      idx = ID_W'((int'(start) + k) % N_DEV);
      if (pend[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  always_comb begin
    toggle     = dev_status ^ status_q;
    grantRaw   = findGrant(pend_q, ptr_q);
    grantValid = grantRaw[ID_W];
    grantIdx   = grantRaw[ID_W-1:0];
    grantVec   = grantValid ? (N_DEV'(1) << grantIdx) : '0;
    pend_d     = (pend_q & ~grantVec) ^ toggle;
    dir_d      = (toggle & dev_status) | (~toggle & dir_q);
    ptr_d      = (grantIdx == ID_W'(N_DEV - 1)) ? '0 : grantIdx + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      pend_q   <= '0;
      dir_q    <= '0;
      ptr_q    <= '0;
      change_q <= 1'b0;
      onOff_q  <= 1'b0;
      devId_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      status_q <= dev_status;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      busy_q   <= |pend_d;
      if (grantValid) begin
        change_q <= 1'b1;
        onOff_q  <= dir_q[grantIdx];
        devId_q  <= grantIdx;
        ptr_q    <= ptr_d;
      end else begin
        change_q <= 1'b0;
        onOff_q  <= 1'b0;
        devId_q  <= '0;
      end
    end
  end

  assign change = change_q;
  assign on_off = onOff_q;
  assign dev_id = devId_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_device_event_encoder.sv
// Bench for device_event_encoder: directed scenarios plus random toggling, checked against an
// event-list model of pending connect/disconnect notifications.
module tb_device_event_encoder;

  localparam int N_DEV = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_DEV-1:0] dev_status;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Model state: which devices owe a notification, in which direction, and where the search starts.
  bit mStatus[N_DEV];
  bit mPend[N_DEV];
  bit mDir[N_DEV];
  int mPtr;
  bit eChange;
  bit eOnOff;
  int eId;
  bit eBusy;
  int netCount;

  device_event_encoder #(.N_DEV(N_DEV), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dev_status (dev_status),
    .change     (change),
    .on_off     (on_off),
    .dev_id     (dev_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit r, input logic [N_DEV-1:0] s);
    int g;
    eChange = 0;
    eOnOff  = 0;
    eId     = 0;
    if (r) begin
      for (int i = 0; i < N_DEV; i++) begin
        mStatus[i] = 0;
        mPend[i]   = 0;
        mDir[i]    = 0;
      end
      mPtr  = 0;
      eBusy = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < N_DEV; k++) begin
      if (g < 0 && mPend[(mPtr + k) % N_DEV]) g = (mPtr + k) % N_DEV;
    end
    if (g >= 0) begin
      eChange  = 1;
      eOnOff   = mDir[g];
      eId      = g;
      mPtr     = (g + 1) % N_DEV;
      mPend[g] = 0;
    end
    // An unannounced toggle is withdrawn by the opposite toggle; otherwise it becomes a new notification.
    for (int i = 0; i < N_DEV; i++) begin
      if (s[i] != mStatus[i]) begin
        if (mPend[i]) begin
          mPend[i] = 0;
        end else begin
          mPend[i] = 1;
          mDir[i]  = s[i];
        end
        mStatus[i] = s[i];
      end
    end
    eBusy = 0;
    for (int i = 0; i < N_DEV; i++) eBusy |= mPend[i];
  endtask

  function automatic logic [5:0] modelOut();
    logic [ID_W-1:0] idv;
    idv = ID_W'(eId);
    return {eChange, eOnOff, idv, eBusy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep(rst, dev_status);
    if (rst) netCount = 0;
    else if (change) netCount += on_off ? 1 : -1;
  endtask

  task automatic applyReset();
    rst        = 1'b1;
    dev_status = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst        = 1'b1;
    dev_status = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== 6'b0) begin
        bad++;
        $display("[TB] FAIL reset_state cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, 6'b0);
      end
    end
    rst        = 1'b0;
    dev_status = 8'h20;
    pulses     = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL reset_first_event cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
      if (change) begin
        pulses++;
        total++;
        if (c != 1 || on_off !== 1'b1 || dev_id !== 3'd5) begin
          bad++;
          $display("[TB] FAIL reset_pulse: got cycle %0d on_off %b id %0d want cycle 1 on_off 1 id 5", c, on_off, dev_id);
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("[TB] FAIL reset_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_burst();
    int evs[$];
    int busyCycles;
    applyReset();
    dev_status = 8'hFF;
    busyCycles = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL burst cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
      if (busy) busyCycles++;
      if (change) evs.push_back(int'(on_off) * 16 + int'(dev_id));
    end
    total++;
    if (evs.size() != 8) begin
      bad++;
      $display("[TB] FAIL burst_events: got %0d want 8", evs.size());
    end
    for (int i = 0; i < evs.size() && i < 8; i++) begin
      total++;
      if (evs[i] != 16 + i) begin
        bad++;
        $display("[TB] FAIL burst_order[%0d]: got %0d want %0d", i, evs[i], 16 + i);
      end
    end
    total++;
    if (busyCycles != 8) begin
      bad++;
      $display("[TB] FAIL burst_busy: got %0d want 8", busyCycles);
    end
    total++;
    if (netCount != 8) begin
      bad++;
      $display("[TB] FAIL burst_count: got %0d want 8", netCount);
    end
  endtask

  task automatic test_cancel();
    int evs[$];
    int want[$] = '{16, 17, 18};
    applyReset();
    dev_status = 8'h0F;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) dev_status = 8'h07;
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL cancel cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
      if (change) evs.push_back(int'(on_off) * 16 + int'(dev_id));
    end
    total++;
    if (evs.size() != want.size()) begin
      bad++;
      $display("[TB] FAIL cancel_events: got %0d want %0d", evs.size(), want.size());
    end
    for (int i = 0; i < evs.size() && i < want.size(); i++) begin
      total++;
      if (evs[i] != want[i]) begin
        bad++;
        $display("[TB] FAIL cancel_order[%0d]: got %0d want %0d", i, evs[i], want[i]);
      end
    end
    total++;
    if (netCount != 3) begin
      bad++;
      $display("[TB] FAIL cancel_count: got %0d want 3", netCount);
    end
  endtask

  task automatic test_round_robin();
    int evs[$];
    int want[$] = '{22, 23, 18};
    applyReset();
    dev_status = 8'h40;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) dev_status = 8'hC4;
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL round_robin cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
      if (change) evs.push_back(int'(on_off) * 16 + int'(dev_id));
    end
    total++;
    if (evs.size() != want.size()) begin
      bad++;
      $display("[TB] FAIL rr_events: got %0d want %0d", evs.size(), want.size());
    end
    for (int i = 0; i < evs.size() && i < want.size(); i++) begin
      total++;
      if (evs[i] != want[i]) begin
        bad++;
        $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", i, evs[i], want[i]);
      end
    end
  endtask

  task automatic test_grant_toggle();
    int evs[$];
    int want[$] = '{20, 4};
    applyReset();
    dev_status = 8'h10;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) dev_status = 8'h00;
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL grant_toggle cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
      if (change) evs.push_back(int'(on_off) * 16 + int'(dev_id));
    end
    total++;
    if (evs.size() != want.size()) begin
      bad++;
      $display("[TB] FAIL gt_events: got %0d want %0d", evs.size(), want.size());
    end
    for (int i = 0; i < evs.size() && i < want.size(); i++) begin
      total++;
      if (evs[i] != want[i]) begin
        bad++;
        $display("[TB] FAIL gt_order[%0d]: got %0d want %0d", i, evs[i], want[i]);
      end
    end
    total++;
    if (netCount != 0) begin
      bad++;
      $display("[TB] FAIL gt_count: got %0d want 0", netCount);
    end
  endtask

  task automatic test_reset_mid();
    int evs[$];
    int want[$] = '{20, 21, 22, 23};
    applyReset();
    dev_status = 8'hF0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL reset_mid_pre cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if ({change, on_off, dev_id, busy} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_clear: got %b want %b", {change, on_off, dev_id, busy}, 6'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL reset_mid_post cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
      if (change) evs.push_back(int'(on_off) * 16 + int'(dev_id));
    end
    total++;
    if (evs.size() != want.size()) begin
      bad++;
      $display("[TB] FAIL reset_mid_events: got %0d want %0d", evs.size(), want.size());
    end
    for (int i = 0; i < evs.size() && i < want.size(); i++) begin
      total++;
      if (evs[i] != want[i]) begin
        bad++;
        $display("[TB] FAIL reset_mid_order[%0d]: got %0d want %0d", i, evs[i], want[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(2) == 0) dev_status = dev_status ^ N_DEV'($urandom & $urandom);
      tick();
      total++;
      if ({change, on_off, dev_id, busy} !== modelOut()) begin
        bad++;
        $display("[TB] FAIL random cycle %0d: got %b want %b", c, {change, on_off, dev_id, busy}, modelOut());
      end
    end
    rst = 1'b0;
    tick();
    tick();
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("[TB] FAIL random_settle: got busy after %0d cycles want idle", n);
    end
    total++;
    if (netCount != $countones(dev_status)) begin
      bad++;
      $display("[TB] FAIL random_invariant: got net %0d want %0d", netCount, $countones(dev_status));
    end
  endtask

  initial begin
    rst        = 1'b1;
    dev_status = '0;
    netCount   = 0;
    modelStep(1'b1, '0);
    test_reset();
    test_burst();
    test_cancel();
    test_round_robin();
    test_grant_toggle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
